audio_mixer_nch: RTL and testbench
==================================

Name: audio_mixer_nch

Overview:
Parametrised, time-multiplexed N-channel audio mixer for the ACP sound path.
- On each `sample_tick` it snapshots all channel samples, volumes and mutes.
- It accumulates one volume-scaled channel per clock, then emits one saturated mixed sample with a single-cycle valid strobe.
- It replaces the fixed 4-channel combinational mixer: per-channel volume on every channel, saturation instead of wrap, and overrun detection.

Parameters:
- NUM_CH, 4, number of input channels (>=1).
- IN_W, 4, width of each unsigned channel sample.
- VOL_W, 2, width of each channel volume code.
- OUT_W, 8, width of the mixed output sample.
- SHIFT, 0, right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_tick  in  1  one-cycle strobe: start a mix of the current inputs.
- in_bus  in  NUM_CH*IN_W  channel samples; channel k at [k*IN_W +: IN_W].
- vol_bus  in  NUM_CH*VOL_W  volume codes; channel k at [k*VOL_W +: VOL_W].
- mute  in  NUM_CH  per-channel mute; 1 forces that channel's term to 0.
- overrun_clr  in  1  clears the sticky overrun flag.
- out  out  OUT_W  last mixed sample, held between updates.
- out_valid  out  1  one-cycle pulse when `out` updates.
- busy  out  1  high while a mix is in progress.
- overrun  out  1  sticky: a tick arrived while busy.

Behaviour:
- Reset (async, active-high):
  - Outputs: out=0, out_valid=0, busy=0, overrun=0.
  - Internal: state=IDLE, acc=0, idx=0.
  - Reset asserted mid-mix abandons the mix; no out_valid is produced.
- Per-channel term: term_k = in_k * (vol_k + 1), width IN_W+VOL_W.
  - With VOL_W=2 the gains are 1/4, 1/2, 3/4 and full of in<<2.
  - Volume codes are linear; no Gray ordering.
- Accumulator width: ACC_W = IN_W + VOL_W + clog2(NUM_CH); it never wraps.
- Output value: out = min(acc >> SHIFT, 2^OUT_W - 1), i.e. unsigned saturation.
- FSM states: IDLE, ACCUM, EMIT.
  - IDLE: on sample_tick, latch in_bus, vol_bus and mute into snapshot registers; set acc=0, idx=0; go to ACCUM. Otherwise stay.
  - ACCUM: acc += term_idx from the snapshot. If idx == NUM_CH-1 go to EMIT, else idx++.
  - EMIT: register out, pulse out_valid for exactly one cycle, go to IDLE.
- Timing:
  - Latency: tick sampled at edge T gives out_valid high in cycle T+NUM_CH+1.
  - Maximum tick rate is one per NUM_CH+2 cycles.
  - busy is 1 in ACCUM and EMIT, 0 in IDLE.
- Input snapshot: changes to in_bus, vol_bus or mute after the tick do not affect the mix in progress.
- Overrun:
  - A sample_tick while in ACCUM or EMIT is ignored (no restart) and sets overrun.
  - overrun_clr clears overrun.
  - If set and clear occur in the same cycle, set wins.
- out holds its value between EMIT cycles; out_valid is 0 at all other times.
- NUM_CH=1: ACCUM lasts one cycle.

Decomposition:
- Package mixer_pkg:
  - state enum {IDLE, ACCUM, EMIT}.
  - clog2 function.
  - ACC_W derivation helper.
- Sub-module mixer_ch_scale: combinational term = mute ? 0 : in*(vol+1), parametrised on IN_W and VOL_W.
  - Instantiated once, fed by the idx-selected snapshot channel.

Test Plan:
- Defaults; all in=15, vol=3, mute=0; one tick → busy for 5 cycles, out_valid at T+5, out=240, overrun=0.
- Volume sweep on ch0 (others muted), in0=8, vol0=0,1,2,3 on successive ticks → out=8, 16, 24, 32.
- NUM_CH=8, all in=15, vol=3 → raw sum 480 saturates to out=255. Same case with SHIFT=1 → out=240.
- Tick at T, inputs changed to 0 at T+1, second tick at T+2 → out reflects the T snapshot; only one out_valid; overrun=1. overrun_clr pulse → overrun=0. Simultaneous tick-while-busy and clr → overrun stays 1.
- mute=4'b1010, all in=15, vol=3 → out=120.
- rst asserted at T+2 mid-mix, released → no out_valid, out=0, busy=0. Next tick mixes normally.

Source files
------------

// File: rtl/mixer_pkg.sv
// Shared types and width helpers for the time-multiplexed audio mixer.
package mixer_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // The sum of NUM_CH full-scale terms always fits, so the accumulator never wraps.
  function automatic int acc_width(input int in_w, input int vol_w, input int num_ch);
    return in_w + vol_w + clog2(num_ch);
  endfunction

endpackage

// File: rtl/mixer_ch_scale.sv
// Volume scaling of one channel sample: term = mute ? 0 : sample * (vol + 1).
module mixer_ch_scale #(
  parameter int IN_W  = 4,
  parameter int VOL_W = 2
) (
  input  logic [IN_W-1:0]       sample,
  input  logic [VOL_W-1:0]      vol,
  input  logic                  mute,
  output logic [IN_W+VOL_W-1:0] term
);

  localparam int PROD_W = IN_W + VOL_W + 1;

  logic [VOL_W:0]    gain;
  logic [PROD_W-1:0] prod;

  assign gain = {1'b0, vol} + (VOL_W + 1)'(1);
  assign prod = PROD_W'(sample) * PROD_W'(gain);

  // The top product bit is always zero: the largest product is (2^IN_W-1)*2^VOL_W.
  assign term = mute ? '0 : prod[IN_W+VOL_W-1:0];

endmodule

// File: rtl/audio_mixer_nch.sv
// N-channel mixer: snapshots inputs on sample_tick, accumulates one scaled channel
// per clock, then emits one saturated sample with a single-cycle valid strobe.
import mixer_pkg::*;

module audio_mixer_nch #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 4,
  parameter int VOL_W  = 2,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_tick,
  input  logic [NUM_CH*IN_W-1:0]  in_bus,
  input  logic [NUM_CH*VOL_W-1:0] vol_bus,
  input  logic [NUM_CH-1:0]       mute,
  input  logic                    overrun_clr,
  output logic [OUT_W-1:0]        out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int ACC_W  = acc_width(IN_W, VOL_W, NUM_CH);
  localparam int IDX_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int TERM_W = IN_W + VOL_W;
  localparam int CMP_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_t state, state_next;

  logic [IN_W-1:0]   in_snap   [NUM_CH];
  logic [VOL_W-1:0]  vol_snap  [NUM_CH];
  logic [NUM_CH-1:0] mute_snap;

  logic [IDX_W-1:0]  idx;
  logic [ACC_W-1:0]  acc;
  logic [TERM_W-1:0] term;
  logic [CMP_W-1:0]  shifted;
  logic [CMP_W-1:0]  sat_max;
  logic [OUT_W-1:0]  mixed;
  logic              start;

  assign start = (state == IDLE) && sample_tick;
  assign busy  = (state != IDLE);

  mixer_ch_scale #(
    .IN_W  (IN_W),
    .VOL_W (VOL_W)
  ) u_scale (
    .sample (in_snap[idx]),
    .vol    (vol_snap[idx]),
    .mute   (mute_snap[idx]),
    .term   (term)
  );

  assign shifted = CMP_W'(acc >> SHIFT);
  assign sat_max = CMP_W'({OUT_W{1'b1}});
  assign mixed   = (shifted > sat_max) ? '1 : shifted[OUT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_tick) state_next = ACCUM;
      ACCUM:   if (idx == LAST_IDX) state_next = EMIT;
      EMIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Snapshot registers need no reset; they are only read after a tick loads them.
  always_ff @(posedge clk) begin
    if (start) begin
      for (int k = 0; k < NUM_CH; k++) begin
        in_snap[k]  <= in_bus[k*IN_W +: IN_W];
        vol_snap[k] <= vol_bus[k*VOL_W +: VOL_W];
      end
      mute_snap <= mute;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      idx       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state == EMIT);
      if (start) begin
        acc <= '0;
        idx <= '0;
      end else if (state == ACCUM) begin
        acc <= acc + ACC_W'(term);
        if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
      end
      if (state == EMIT) out <= mixed;
    end
  end

  // A tick that lands mid-mix is dropped; setting outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       overrun <= 1'b0;
    else if (sample_tick && busy)  overrun <= 1'b1;
    else if (overrun_clr)          overrun <= 1'b0;
  end

endmodule

// File: tb/tb_audio_mixer_nch.sv
// Directed self-checking bench for audio_mixer_nch (4-channel default and 8-channel variants).
module tb_audio_mixer_nch;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic [15:0] in_bus;
  logic [7:0]  vol_bus;
  logic [3:0]  mute;
  logic        overrun_clr;
  logic [7:0]  out;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  logic        tick8;
  logic [31:0] in_bus8;
  logic [15:0] vol_bus8;
  logic [7:0]  mute8;
  logic [7:0]  out8a, out8b;
  logic        out_valid8a, out_valid8b;
  logic        busy8a, busy8b;
  logic        overrun8a, overrun8b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  audio_mixer_nch dut (
    .clk (clk), .rst (rst), .sample_tick (sample_tick),
    .in_bus (in_bus), .vol_bus (vol_bus), .mute (mute),
    .overrun_clr (overrun_clr), .out (out), .out_valid (out_valid),
    .busy (busy), .overrun (overrun)
  );

  audio_mixer_nch #(.NUM_CH(8), .SHIFT(0)) dut8 (
    .clk (clk), .rst (rst), .sample_tick (tick8),
    .in_bus (in_bus8), .vol_bus (vol_bus8), .mute (mute8),
    .overrun_clr (1'b0), .out (out8a), .out_valid (out_valid8a),
    .busy (busy8a), .overrun (overrun8a)
  );

  audio_mixer_nch #(.NUM_CH(8), .SHIFT(1)) dut8s (
    .clk (clk), .rst (rst), .sample_tick (tick8),
    .in_bus (in_bus8), .vol_bus (vol_bus8), .mute (mute8),
    .overrun_clr (1'b0), .out (out8b), .out_valid (out_valid8b),
    .busy (busy8b), .overrun (overrun8b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] ins, input logic [7:0] vols, input logic [3:0] mutes);
    in_bus  = ins;
    vol_bus = vols;
    mute    = mutes;
  endtask

  // Called at a negedge; steps negedges until out_valid, bounded.
  task automatic waitValid(input int start, output int latency, output int busyCount);
    latency   = start;
    busyCount = 0;
    while (!out_valid && latency < 40) begin
      busyCount += int'(busy);
      @(negedge clk);
      latency++;
    end
  endtask

  task automatic doMix(input string tag, input int expOut);
    int lat, bc;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    waitValid(0, lat, bc);
    checkOutput({tag, "_latency"}, lat, 5);
    checkOutput({tag, "_busy"}, bc, 5);
    checkOutput({tag, "_out"}, {24'd0, out}, expOut);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, {31'd0, out_valid}, 0);
  endtask

  task automatic countValids(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      n += int'(out_valid);
    end
  endtask

  initial begin
    int lat, bc, nv;
    rst = 1'b1;
    sample_tick = 1'b0;
    overrun_clr = 1'b0;
    tick8 = 1'b0;
    in_bus8 = '0;
    vol_bus8 = '0;
    mute8 = '0;
    applyStimulus(16'h0000, 8'h00, 4'h0);
    repeat (3) @(negedge clk);
    checkOutput("reset_out", {24'd0, out}, 0);
    checkOutput("reset_valid", {31'd0, out_valid}, 0);
    checkOutput("reset_busy", {31'd0, busy}, 0);
    checkOutput("reset_overrun", {31'd0, overrun}, 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(16'hFFFF, 8'hFF, 4'h0);
    doMix("full", 240);
    checkOutput("full_overrun", {31'd0, overrun}, 0);

    for (int v = 0; v < 4; v++) begin
      applyStimulus(16'h0008, 8'(v), 4'b1110);
      doMix($sformatf("vol%0d", v), 8 * (v + 1));
    end

    applyStimulus(16'hFFFF, 8'hFF, 4'b1010);
    doMix("mute1010", 120);

    // Inputs zeroed right after the tick; a second tick arrives mid-mix.
    applyStimulus(16'hFFFF, 8'hFF, 4'h0);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    applyStimulus(16'h0000, 8'h00, 4'h0);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    waitValid(2, lat, bc);
    checkOutput("snap_latency", lat, 5);
    checkOutput("snap_out", {24'd0, out}, 240);
    checkOutput("snap_overrun", {31'd0, overrun}, 1);
    countValids(12, nv);
    checkOutput("snap_single_valid", nv, 0);

    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    checkOutput("clr_overrun", {31'd0, overrun}, 0);

    // Set and clear in the same cycle: set must win.
    applyStimulus(16'hFFFF, 8'hFF, 4'b1010);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    sample_tick = 1'b1;
    overrun_clr = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    overrun_clr = 1'b0;
    checkOutput("setclr_overrun", {31'd0, overrun}, 1);
    waitValid(2, lat, bc);
    checkOutput("setclr_out", {24'd0, out}, 120);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;

    // Reset in the middle of a mix.
    applyStimulus(16'hFFFF, 8'hFF, 4'h0);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_out", {24'd0, out}, 0);
    checkOutput("midrst_busy", {31'd0, busy}, 0);
    checkOutput("midrst_valid", {31'd0, out_valid}, 0);
    countValids(12, nv);
    checkOutput("midrst_no_valid", nv, 0);
    doMix("after_rst", 240);

    // Eight channels: raw sum 480 saturates at 255, or 240 after a shift of one.
    in_bus8  = {8{4'hF}};
    vol_bus8 = {8{2'd3}};
    mute8    = 8'h00;
    tick8 = 1'b1;
    @(negedge clk);
    tick8 = 1'b0;
    lat = 0;
    while (!out_valid8a && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("ch8_latency", lat, 9);
    checkOutput("ch8_sat_out", {24'd0, out8a}, 255);
    checkOutput("ch8_shift_valid", {31'd0, out_valid8b}, 1);
    checkOutput("ch8_shift_out", {24'd0, out8b}, 240);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
